// File: rtl/sparc_cu_pkg.sv
// Shared control-unit definitions: SPARC V8 field constants, the fixed
// 5-bit next-state codes, field extraction helpers and the decode result
// record produced by the combinational decoder.
package sparc_cu_pkg;

    // Width of the literal state codes below; wider STATE_W zero-extends.
    localparam int CODE_W = 5;

    // Control-unit next-state codes.
    localparam logic [CODE_W-1:0] ST_BRANCH    = 5'd25;
    localparam logic [CODE_W-1:0] ST_SETHI     = 5'd9;
    localparam logic [CODE_W-1:0] ST_CALL      = 5'd10;
    localparam logic [CODE_W-1:0] ST_JMPL      = 5'd12;
    localparam logic [CODE_W-1:0] ST_ARITH_R   = 5'd5;
    localparam logic [CODE_W-1:0] ST_ARITH_I   = 5'd7;
    localparam logic [CODE_W-1:0] ST_ARITHCC_R = 5'd6;
    localparam logic [CODE_W-1:0] ST_ARITHCC_I = 5'd8;
    localparam logic [CODE_W-1:0] ST_LOAD_R    = 5'd16;
    localparam logic [CODE_W-1:0] ST_LOAD_I    = 5'd20;
    localparam logic [CODE_W-1:0] ST_STORE_R   = 5'd21;
    localparam logic [CODE_W-1:0] ST_STORE_I   = 5'd24;

    // Instruction format selector, bits [31:30].
    typedef enum logic [1:0] {
        OP_FMT2 = 2'b00,   // branches and sethi
        OP_CALL = 2'b01,   // call
        OP_ALU  = 2'b10,   // arithmetic, logic, shifts, jmpl
        OP_MEM  = 2'b11    // loads and stores
    } op_e;

    // op2 values for format-2 instructions.
    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    // op3 values for op=10.
    localparam logic [5:0] OP3_JMPL = 6'b111000;
    localparam logic [5:0] OP3_SLL  = 6'b100101;
    localparam logic [5:0] OP3_SRL  = 6'b100110;
    localparam logic [5:0] OP3_SRA  = 6'b100111;

    // op3 values for op=11 (integer loads).
    localparam logic [5:0] OP3_LD   = 6'b000000;
    localparam logic [5:0] OP3_LDUB = 6'b000001;
    localparam logic [5:0] OP3_LDUH = 6'b000010;
    localparam logic [5:0] OP3_LDD  = 6'b000011;
    localparam logic [5:0] OP3_LDSB = 6'b001001;
    localparam logic [5:0] OP3_LDSH = 6'b001010;

    // op3 values for op=11 (integer stores).
    localparam logic [5:0] OP3_ST   = 6'b000100;
    localparam logic [5:0] OP3_STB  = 6'b000101;
    localparam logic [5:0] OP3_STH  = 6'b000110;
    localparam logic [5:0] OP3_STD  = 6'b000111;

    // Decoder output: fixed-width code plus unrecognised-encoding flag.
    typedef struct packed {
        logic [CODE_W-1:0] state;
        logic              illegal;
    } decode_t;

    // Field extraction from the low 32 bits of an instruction word.
    function automatic op_e get_op(input logic [31:0] w);
        return op_e'(w[31:30]);
    endfunction

    function automatic logic [2:0] get_op2(input logic [31:0] w);
        return w[24:22];
    endfunction

    function automatic logic [5:0] get_op3(input logic [31:0] w);
        return w[24:19];
    endfunction

    function automatic logic get_i(input logic [31:0] w);
        return w[13];
    endfunction

endpackage

// File: rtl/sparc_decode_queue_if.sv
// Handshake bundle between the instruction register (master side) and the
// decode queue (slave side): input word channel, output state channel and
// occupancy.
interface sparc_decode_queue_if #(
    parameter int INSTR_W = 32,
    parameter int STATE_W = 5,
    parameter int DEPTH   = 2
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [INSTR_W-1:0]       instr;
    logic                     out_valid;
    logic                     out_ready;
    logic [STATE_W-1:0]       next_state;
    logic                     illegal;
    logic [$clog2(DEPTH):0]   count;

    // Producer of instruction words and consumer of decoded states.
    modport master (
        output in_valid,
        output instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  next_state,
        input  illegal,
        input  count
    );

    // The decode queue itself.
    modport slave (
        input  in_valid,
        input  instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output next_state,
        output illegal,
        output count
    );

endinterface

// File: rtl/sparc_decode_comb.sv
// Pure combinational SPARC V8 instruction decoder: maps an instruction word
// to a fixed-width control-unit state code and flags encodings it does not
// recognise (state is left at zero for those; the caller substitutes).
module sparc_decode_comb
    import sparc_cu_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] instr_i,
    output decode_t            dec_o
);

    logic [31:0] word;
    op_e         op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic        imm;

    // Fields sit at fixed V8 positions in the low 32 bits; any extra upper
    // bits carry no decode information.
    assign word = instr_i[31:0];
    assign op   = get_op(word);
    assign op2  = get_op2(word);
    assign op3  = get_op3(word);
    assign imm  = get_i(word);

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i;

    // Decode op/op2/op3/i into a next-state code.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        dec_o.state   = '0;
        dec_o.illegal = 1'b1;
        case (op)
            OP_FMT2: begin
                if (op2 == OP2_BICC) begin
                    dec_o.state   = ST_BRANCH;
                    dec_o.illegal = 1'b0;
                end else if (op2 == OP2_SETHI) begin
                    dec_o.state   = ST_SETHI;
                    dec_o.illegal = 1'b0;
                end
            end
            OP_CALL: begin
                dec_o.state   = ST_CALL;
                dec_o.illegal = 1'b0;
            end
            OP_ALU: begin
                if (op3 == OP3_JMPL) begin
                    dec_o.state   = ST_JMPL;
                    dec_o.illegal = 1'b0;
                end else if (op3 == OP3_SLL || op3 == OP3_SRL || op3 == OP3_SRA) begin
                    dec_o.state   = imm ? ST_ARITH_I : ST_ARITH_R;
                    dec_o.illegal = 1'b0;
                end else if (!op3[5] &&
                             (!op3[3] || op3[2:0] == 3'b000 || op3[2:0] == 3'b100)) begin
                    // op3[4] separates the condition-code-setting variants.
                    if (op3[4]) begin
                        dec_o.state = imm ? ST_ARITHCC_I : ST_ARITHCC_R;
                    end else begin
                        dec_o.state = imm ? ST_ARITH_I : ST_ARITH_R;
                    end
                    dec_o.illegal = 1'b0;
                end
            end
            OP_MEM: begin
                case (op3)
                    OP3_LD, OP3_LDUB, OP3_LDUH, OP3_LDD, OP3_LDSB, OP3_LDSH: begin
                        dec_o.state   = imm ? ST_LOAD_I : ST_LOAD_R;
                        dec_o.illegal = 1'b0;
                    end
                    OP3_ST, OP3_STB, OP3_STH, OP3_STD: begin
                        dec_o.state   = imm ? ST_STORE_I : ST_STORE_R;
                        dec_o.illegal = 1'b0;
                    end
                    default: begin
                        dec_o.state   = '0;
                        dec_o.illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_o.state   = '0;
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sparc_decode_queue.sv
// Registered SPARC decode stage: decodes each accepted instruction word and
// buffers {next_state, illegal} in a DEPTH-entry FIFO with valid/ready
// handshakes on both sides. No combinational path from instr to next_state.
// Build option: define ILLEGAL_TRAP_EN to push ST_TRAP for unrecognised
// encodings; otherwise ST_FETCH is pushed. The illegal flag is set either way.
module sparc_decode_queue
    import sparc_cu_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int STATE_W  = 5,
    parameter int DEPTH    = 2,
    parameter int ST_FETCH = 0,
    parameter int ST_TRAP  = 31
) (
    input logic               clk,
    input logic               reset_n,
    sparc_decode_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef ILLEGAL_TRAP_EN
    localparam logic [STATE_W-1:0] UNREC_CODE = STATE_W'(ST_TRAP);
`else
    localparam logic [STATE_W-1:0] UNREC_CODE = STATE_W'(ST_FETCH);
`endif

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic               illegal;
    } entry_t;

    decode_t           dec;
    entry_t            push_entry;
    entry_t            head;
    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  head_idx;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    sparc_decode_comb #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .instr_i (bus.instr),
        .dec_o   (dec)
    );

    // Substitute the configured code for unrecognised encodings and widen.
    always_comb begin
        push_entry.illegal = dec.illegal;
        push_entry.state   = dec.illegal ? UNREC_CODE : STATE_W'(dec.state);
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // A full queue refuses new words even when the head pops this cycle.
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.out_ready;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; written at the write pointer on every accepted word.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: storage is reset because the output reads it directly and must show 0 after reset.
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // When empty the slot just behind the read pointer still holds the last
    // popped entry (nothing writes there until the queue refills), so the
    // outputs keep that value instead of a stale older one.
    assign head_idx = empty ? (rd_ptr_q - PTR_W'(1)) : rd_ptr_q;
    assign head     = mem_q[head_idx];

    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign bus.next_state = head.state;
    assign bus.illegal    = head.illegal;
    assign bus.count      = count_q;

endmodule
